// File: rtl/ne_chan_sched.sv
`default_nettype none
// ============================================================================
// ne_chan_sched -- round-robin scheduler of NUM_CH sample streams onto one
// shared NE datapath; NE_SCHED_WIN_EN adds per-channel window-end tags.
// Revision: 1.0
// ============================================================================
module ne_chan_sched #(
  parameter int NUM_CH       = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int OUTPUT_WIDTH = 40,
  parameter int DP_LATENCY   = 3,
  parameter int WIN_LEN      = 256
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           en_i,
  input  logic [NUM_CH-1:0]              ch_valid_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data_i,
  output logic [NUM_CH-1:0]              ch_ready_o,
  output logic                           dp_en_o,
  output logic [DATA_WIDTH-1:0]          dp_din_o,
  output logic [$clog2(NUM_CH)-1:0]      dp_ch_o,
  input  logic [OUTPUT_WIDTH-1:0]        dp_dout_i,
  input  logic                           dp_valid_i,
  output logic                           res_valid_o,
  output logic [OUTPUT_WIDTH-1:0]        res_data_o,
  output logic [$clog2(NUM_CH)-1:0]      res_ch_o,
  output logic                           res_last_o,
  output logic                           err_o
);

  localparam int CH_W = $clog2(NUM_CH);

  if (NUM_CH < 2 || NUM_CH > 16 || DP_LATENCY < 1 || DP_LATENCY > 8 || WIN_LEN < 2)
  begin : g_bad_param
    $error("ne_chan_sched: parameter out of range");
  end

  logic [NUM_CH-1:0]     hold_full_q;
  logic [DATA_WIDTH-1:0] hold_data_q [NUM_CH];
  logic [CH_W-1:0]       ptr_q, ptr_d;

  logic [NUM_CH-1:0]     cand;
  logic [NUM_CH-1:0]     grant;
  logic                  grant_vld;
  logic [CH_W-1:0]       grant_idx;
  logic                  issue_last;

  logic                  dp_en_q;
  logic [DATA_WIDTH-1:0] dp_din_q;
  logic [CH_W-1:0]       dp_ch_q;
  logic                  dp_last_q;

  logic                  tag_v_q    [DP_LATENCY];
  logic [CH_W-1:0]       tag_ch_q   [DP_LATENCY];
  logic                  tag_last_q [DP_LATENCY];

  logic                    res_valid_q;
  logic [OUTPUT_WIDTH-1:0] res_data_q;
  logic [CH_W-1:0]         res_ch_q;
  logic                    res_last_q;
  logic                    err_q;

  assign cand       = hold_full_q & {NUM_CH{en_i}};
  assign ch_ready_o = ~hold_full_q | grant;

  // Rotating priority: first candidate at or above ptr, wrapping modulo NUM_CH.
  always_comb begin
    logic [CH_W:0] sum;
    grant     = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    sum       = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sum = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (sum >= (CH_W+1)'(NUM_CH)) begin
        sum = sum - (CH_W+1)'(NUM_CH);
      end
      if (!grant_vld && cand[sum[CH_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = sum[CH_W-1:0];
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      ptr_d = (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
    end
  end

`ifdef NE_SCHED_WIN_EN
  localparam int CNT_W = $clog2(WIN_LEN);

  logic [CNT_W-1:0] win_cnt_q [NUM_CH];
  logic [CNT_W-1:0] win_cnt_d;

  // The issue that finds the counter already at WIN_LEN-1 closes the window.
  always_comb begin
    issue_last = grant_vld && (win_cnt_q[grant_idx] == CNT_W'(WIN_LEN-1));
    win_cnt_d  = issue_last ? '0 : win_cnt_q[grant_idx] + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        win_cnt_q[i] <= '0;
      end
    end else if (grant_vld) begin
      win_cnt_q[grant_idx] <= win_cnt_d;
    end
  end
`else
  assign issue_last = 1'b0;
`endif

  // Same-edge load and grant keeps the register full with the newer sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_full_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        hold_data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid_i[i] && ch_ready_o[i]) begin
          hold_full_q[i] <= 1'b1;
          hold_data_q[i] <= ch_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end else if (grant[i]) begin
          hold_full_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q     <= '0;
      dp_en_q   <= 1'b0;
      dp_din_q  <= '0;
      dp_ch_q   <= '0;
      dp_last_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      if (grant_vld) begin
        dp_en_q   <= 1'b1;
        dp_din_q  <= hold_data_q[grant_idx];
        dp_ch_q   <= grant_idx;
        dp_last_q <= issue_last;
      end else begin
        dp_en_q   <= 1'b0;
        dp_last_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < DP_LATENCY; s++) begin
        tag_v_q[s]    <= 1'b0;
        tag_ch_q[s]   <= '0;
        tag_last_q[s] <= 1'b0;
      end
    end else begin
      tag_v_q[0]    <= dp_en_q;
      tag_ch_q[0]   <= dp_ch_q;
      tag_last_q[0] <= dp_last_q;
      for (int s = 1; s < DP_LATENCY; s++) begin
        tag_v_q[s]    <= tag_v_q[s-1];
        tag_ch_q[s]   <= tag_ch_q[s-1];
        tag_last_q[s] <= tag_last_q[s-1];
      end
    end
  end

  // The tag tail lines up with the cycle the datapath should present a result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ch_q    <= '0;
      res_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      res_valid_q <= tag_v_q[DP_LATENCY-1] & dp_valid_i;
      if (tag_v_q[DP_LATENCY-1] && dp_valid_i) begin
        res_data_q <= dp_dout_i;
        res_ch_q   <= tag_ch_q[DP_LATENCY-1];
        res_last_q <= tag_last_q[DP_LATENCY-1];
      end
      if (tag_v_q[DP_LATENCY-1] != dp_valid_i) begin
        err_q <= 1'b1;
      end
    end
  end

  assign dp_en_o     = dp_en_q;
  assign dp_din_o    = dp_din_q;
  assign dp_ch_o     = dp_ch_q;
  assign res_valid_o = res_valid_q;
  assign res_data_o  = res_data_q;
  assign res_ch_o    = res_ch_q;
  assign res_last_o  = res_last_q;
  assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ne_chan_sched.sv
`default_nettype none
// ============================================================================
// tb_ne_chan_sched -- directed bench with a squaring datapath model.
// Revision: 1.0
// ============================================================================
module tb_ne_chan_sched;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int OW  = 40;
  localparam int LAT = 3;
  localparam int WL  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic [NCH-1:0]  ch_valid = '0;
  logic [NCH*DW-1:0] ch_data = '0;
  logic [NCH-1:0]  ch_ready;
  logic            dp_en;
  logic [DW-1:0]   dp_din;
  logic [1:0]      dp_ch;
  logic [OW-1:0]   dp_dout;
  logic            dp_valid;
  logic            res_valid;
  logic [OW-1:0]   res_data;
  logic [1:0]      res_ch;
  logic            res_last;
  logic            err;

  ne_chan_sched #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .OUTPUT_WIDTH(OW), .DP_LATENCY(LAT), .WIN_LEN(WL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .ch_valid_i(ch_valid), .ch_data_i(ch_data), .ch_ready_o(ch_ready),
    .dp_en_o(dp_en), .dp_din_o(dp_din), .dp_ch_o(dp_ch),
    .dp_dout_i(dp_dout), .dp_valid_i(dp_valid),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_ch_o(res_ch),
    .res_last_o(res_last), .err_o(err)
  );

  always #5 clk = ~clk;

  // Datapath model: dout = din*din, valid LAT cycles after dp_en (LAT-1 when early).
  logic                 early = 1'b0;
  logic [2:0]           m_v = '0;
  logic signed [OW-1:0] m_p [3];
  always @(posedge clk) begin
    m_v    <= {m_v[1:0], dp_en};
    m_p[0] <= $signed(dp_din) * $signed(dp_din);
    m_p[1] <= m_p[0];
    m_p[2] <= m_p[1];
  end
  assign dp_valid = early ? m_v[1] : m_v[2];
  assign dp_dout  = early ? m_p[1] : m_p[2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     dq_ch[$];
  int     dq_din[$];
  int     dq_cyc[$];
  longint rq_data[$];
  int     rq_ch[$];
  int     rq_last[$];
  int     rq_cyc[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (dp_en) begin
        dq_ch.push_back(int'(dp_ch));
        dq_din.push_back(int'(dp_din));
        dq_cyc.push_back(cyc);
      end
      if (res_valid) begin
        rq_data.push_back(longint'(res_data));
        rq_ch.push_back(int'(res_ch));
        rq_last.push_back(int'(res_last));
        rq_cyc.push_back(cyc);
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_q();
    dq_ch.delete(); dq_din.delete(); dq_cyc.delete();
    rq_data.delete(); rq_ch.delete(); rq_last.delete(); rq_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    ch_valid = '0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
  endtask

  initial begin
    int bad;
    int nrdy;
    int acc;
    int exp_last;

    // Reset with random inputs
    en       = 1'($urandom);
    ch_valid = 4'($urandom);
    ch_data  = {$urandom, $urandom};
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ch_ready), 64'hF);
    check("rst_dp_en", 64'(dp_en), 64'd0);
    check("rst_dp_din", 64'(dp_din), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", 64'(res_data), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1; ch_valid = '0; en = 1'b1;
    clear_q();
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (dp_en || res_valid) bad++;
    end
    check("idle_quiet", 64'(bad), 64'd0);

    // Single channel streaming on ch 2
    clear_q();
    nrdy = 0; acc = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) acc = cyc + 1;
      ch_valid = 4'b0100;
      ch_data[47:32] = 16'(k);
      if (!ch_ready[2]) nrdy++;
    end
    @(negedge clk) ch_valid = '0;
    repeat (10) @(negedge clk);
    check("s_ready", 64'(nrdy), 64'd0);
    check("s_issues", 64'(dq_ch.size()), 64'd10);
    for (int i = 0; i < dq_ch.size(); i++) begin
      check("s_dp_ch", 64'(dq_ch[i]), 64'd2);
      check("s_dp_din", 64'(dq_din[i]), 64'(i + 1));
    end
    if (dq_cyc.size() == 10) check("s_consec", 64'(dq_cyc[9] - dq_cyc[0]), 64'd9);
    check("s_results", 64'(rq_data.size()), 64'd10);
    for (int i = 0; i < rq_data.size(); i++) begin
      check("s_res_data", 64'(rq_data[i]), 64'((i + 1) * (i + 1)));
      check("s_res_ch", 64'(rq_ch[i]), 64'd2);
    end
    if (rq_cyc.size() > 0) check("s_latency", 64'(rq_cyc[0] - acc), 64'd5);

    // All four channels continuously valid
    do_reset();
    @(negedge clk);
    ch_valid = 4'hF;
    ch_data  = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      check("rr_ready", 64'(ch_ready), 64'(1 << (j % 4)));
    end
    @(negedge clk) ch_valid = '0;
    repeat (12) @(negedge clk);
    check("rr_issues", 64'(dq_ch.size()), 64'd20);
    for (int i = 0; i < dq_ch.size(); i++) begin
      check("rr_dp_ch", 64'(dq_ch[i]), 64'(i % 4));
      check("rr_dp_din", 64'(dq_din[i]), 64'(17 * ((i % 4) + 1)));
    end
    check("rr_results", 64'(rq_data.size()), 64'd20);

    // Issue freeze with en=0; ptr left at 2 by a ch 1 issue
    do_reset();
    @(negedge clk);
    ch_valid = 4'b0010; ch_data[31:16] = 16'h0021;
    @(negedge clk) ch_valid = '0;
    repeat (8) @(negedge clk);
    clear_q();
    en = 1'b0; ch_valid = 4'b1010;
    ch_data[31:16] = 16'h0021; ch_data[63:48] = 16'h0023;
    @(negedge clk);
    check("en0_ready", 64'(ch_ready & 4'b1010), 64'd0);
    ch_data[31:16] = 16'h0099; ch_data[63:48] = 16'h0099;
    bad = 0;
    repeat (9) begin
      @(negedge clk);
      if (ch_ready[1] || ch_ready[3] || dp_en) bad++;
    end
    check("en0_hold", 64'(bad), 64'd0);
    check("en0_noissue", 64'(dq_ch.size()), 64'd0);
    en = 1'b1; ch_valid = '0;
    #1;
    check("en1_ready", 64'(ch_ready), 64'b1101);
    repeat (8) @(negedge clk);
    check("en1_issues", 64'(dq_ch.size()), 64'd2);
    if (dq_ch.size() == 2) begin
      check("en1_first_ch", 64'(dq_ch[0]), 64'd3);
      check("en1_first_din", 64'(dq_din[0]), 64'h23);
      check("en1_second_ch", 64'(dq_ch[1]), 64'd1);
      check("en1_second_din", 64'(dq_din[1]), 64'h21);
    end

    // Early dp_valid sets sticky err
    do_reset();
    early = 1'b1;
    check("err_pre", 64'(err), 64'd0);
    @(negedge clk);
    ch_valid = 4'b0001; ch_data[15:0] = 16'd5;
    @(negedge clk) ch_valid = '0;
    repeat (8) @(negedge clk);
    check("err_set", 64'(err), 64'd1);
    check("err_nores", 64'(rq_data.size()), 64'd0);
    repeat (10) @(negedge clk);
    check("err_sticky", 64'(err), 64'd1);
    early = 1'b0;
    do_reset();
    @(negedge clk);
    check("err_clr", 64'(err), 64'd0);

    // Window tagging: 9 samples on ch 0
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      ch_valid = 4'b0001; ch_data[15:0] = 16'(k);
    end
    @(negedge clk) ch_valid = '0;
    repeat (10) @(negedge clk);
    check("win_results", 64'(rq_last.size()), 64'd9);
    for (int i = 0; i < rq_last.size(); i++) begin
`ifdef NE_SCHED_WIN_EN
      exp_last = (i == 3 || i == 7) ? 1 : 0;
`else
      exp_last = 0;
`endif
      check("win_last", 64'(rq_last[i]), 64'(exp_last));
    end
    check("win_err", 64'(err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
